// File: rtl/gated_pipe_pkg.sv
// Shared helpers for the gated_pipe elastic pipeline: occupancy width and reset data value.
package gated_pipe_pkg;

    localparam logic RST_DAT_BIT = 1'b0;

    // $clog2(2) is already 1, but keep an explicit floor so a one-stage pipe never gets a zero-width count
    function automatic int unsigned occ_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gated_pipe_stage.sv
// One elastic pipeline stage: valid flop on the free-running clock, data register loaded only on ld.
// Define GATED_PIPE_CLK_GATE_EN to clock the data register from a latch-based clock gate instead of a hold mux.
`ifdef GATED_PIPE_CLK_GATE_EN
module clk_gate (
    input  logic clk_i,
    input  logic en_i,
    output logic gclk_o
);
    logic en_l;

    // Enable is captured only while the clock is low, so gclk_o cannot glitch
    always_latch begin
        if (!clk_i) en_l <= en_i;
    end

    assign gclk_o = clk_i & en_l;
endmodule
`endif

module gated_pipe_stage
    import gated_pipe_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             src_vld_i,
    input  logic [Width-1:0] src_dat_i,
    input  logic             rdy_i,
    output logic             vld_o,
    output logic [Width-1:0] dat_o
);
    logic             vld_q;
    logic             vld_d;
    logic [Width-1:0] dat_q;
    logic [Width-1:0] dat_d;
    logic             ld_c;
    logic             dat_en_c;

    // Flush blocks every load so in-flight data registers keep their contents
    always_comb begin
        ld_c     = src_vld_i & rdy_i & ~flush_i;
        dat_en_c = ld_c | rst_i;
        dat_d    = rst_i ? {Width{RST_DAT_BIT}} : src_dat_i;
        vld_d    = vld_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (rdy_i) begin
            vld_d = src_vld_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) vld_q <= 1'b0;
        else       vld_q <= vld_d;
    end

`ifdef GATED_PIPE_CLK_GATE_EN
    logic gclk;

    clk_gate u_clk_gate (
        .clk_i  (clk_i),
        .en_i   (dat_en_c),
        .gclk_o (gclk)
    );

    always_ff @(posedge gclk) begin
        dat_q <= dat_d;
    end
`else
    always_ff @(posedge clk_i) begin
        if (dat_en_c) dat_q <= dat_d;
    end
`endif

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/gated_pipe.sv
// Elastic valid/ready pipeline of Depth stages whose data registers only clock on a load.
// Build with GATED_PIPE_CLK_GATE_EN to use per-stage clock gates; port behaviour is the same either way.
module gated_pipe
    import gated_pipe_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [Width-1:0]             data_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [Width-1:0]             data_o,
    output logic [occ_width(Depth)-1:0]  occ_o
);
    localparam int unsigned OccW = occ_width(Depth);

    logic [Depth-1:0] vld_c;
    logic [Depth-1:0] rdy_c;
    logic [Width-1:0] dat_c [Depth];

    // Ready ripples from the output side: a stage accepts if it is empty or its successor accepts
    always_comb begin
        logic chain;
        chain = ready_i;
        rdy_c = '0;
        for (int k = int'(Depth) - 1; k >= 0; k--) begin
            chain    = ~vld_c[k] | chain;
            rdy_c[k] = chain;
        end
    end

    always_comb begin
        int unsigned cnt;
        cnt = 0;
        for (int k = 0; k < int'(Depth); k++) begin
            cnt = cnt + 32'(vld_c[k]);
        end
        occ_o = OccW'(cnt);
    end

    for (genvar k = 0; k < Depth; k++) begin : g_stage
        logic             src_vld;
        logic [Width-1:0] src_dat;

        if (k == 0) begin : g_head
            assign src_vld = valid_i;
            assign src_dat = data_i;
        end else begin : g_body
            assign src_vld = vld_c[k-1];
            assign src_dat = dat_c[k-1];
        end

        gated_pipe_stage #(
            .Width (Width)
        ) u_stage (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .flush_i   (flush_i),
            .src_vld_i (src_vld),
            .src_dat_i (src_dat),
            .rdy_i     (rdy_c[k]),
            .vld_o     (vld_c[k]),
            .dat_o     (dat_c[k])
        );
    end

    assign ready_o = rdy_c[0] & ~flush_i;
    assign valid_o = vld_c[Depth-1];
    assign data_o  = dat_c[Depth-1];

endmodule

// File: tb/tb_gated_pipe.sv
// Self-checking bench for gated_pipe (Width=8, Depth=3): directed scenarios plus randomized traffic vs a slot model.
module tb_gated_pipe;
    localparam int unsigned W = 8;
    localparam int unsigned D = 3;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] data_i = '0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [W-1:0] data_o;
    logic [1:0]   occ_o;

    int n_tests = 0;
    int n_fail  = 0;

    gated_pipe #(
        .Width (W),
        .Depth (D)
    ) u_dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .occ_o   (occ_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: D slots that compact toward the output, plus an in-order queue of accepted beats
    bit           m_vld [D];
    logic [W-1:0] m_dat [D];
    logic [W-1:0] sb [$];
    logic [W-1:0] outq [$];
    bit           model_known = 1'b0;
    bit           m_acc;

    logic         obs_ready;
    logic         obs_valid;
    logic [W-1:0] obs_data;
    logic [1:0]   obs_occ;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic flush, input logic acc,
                              input logic [W-1:0] din, input logic rin);
        if (rst) begin
            foreach (m_vld[k]) begin
                m_vld[k] = 1'b0;
                m_dat[k] = '0;
            end
            sb.delete();
            return;
        end
        if (flush) begin
            foreach (m_vld[k]) m_vld[k] = 1'b0;
            sb.delete();
            return;
        end
        if (m_vld[D-1] && rin) begin
            m_vld[D-1] = 1'b0;
            void'(sb.pop_front());
        end
        for (int k = int'(D) - 1; k >= 1; k--) begin
            if (!m_vld[k] && m_vld[k-1]) begin
                m_vld[k]   = 1'b1;
                m_dat[k]   = m_dat[k-1];
                m_vld[k-1] = 1'b0;
            end
        end
        if (acc) begin
            m_vld[0] = 1'b1;
            m_dat[0] = din;
            sb.push_back(din);
        end
    endtask

    // One clock cycle: drive at negedge, sample and check, then advance the model past the next posedge
    task automatic cyc(input logic rst, input logic flush, input logic vin,
                       input logic [W-1:0] din, input logic rin);
        int           cnt;
        logic         exp_ready;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        @(negedge clk_i);
        rst_i   = rst;
        flush_i = flush;
        valid_i = vin;
        data_i  = din;
        ready_i = rin;
        #1;
        obs_ready = ready_o;
        obs_valid = valid_o;
        obs_data  = data_o;
        obs_occ   = occ_o;
        cnt = 0;
        foreach (m_vld[k]) cnt += int'(m_vld[k]);
        exp_ready = !flush && ((cnt < int'(D)) || rin);
        exp_valid = m_vld[D-1];
        exp_data  = (exp_valid && sb.size() > 0) ? sb[0] : m_dat[D-1];
        if (model_known) begin
            check("ready_o", 32'(obs_ready), 32'(exp_ready));
            check("valid_o", 32'(obs_valid), 32'(exp_valid));
            check("data_o",  32'(obs_data),  32'(exp_data));
            check("occ_o",   32'(obs_occ),   32'(cnt));
        end
        if (obs_valid && rin && !rst) outq.push_back(obs_data);
        m_acc = vin && exp_ready;
        model_edge(rst, flush, m_acc, din, rin);
        if (rst) model_known = 1'b1;
    endtask

`ifdef GATED_PIPE_CLK_GATE_EN
    int gp0 = 0;
    int gp1 = 0;
    int gp2 = 0;
    always @(posedge u_dut.g_stage[0].u_stage.gclk) gp0++;
    always @(posedge u_dut.g_stage[1].u_stage.gclk) gp1++;
    always @(posedge u_dut.g_stage[2].u_stage.gclk) gp2++;
`endif

    initial begin
        logic [W-1:0] a_seq [4];
        bit           pend_vld;
        logic [W-1:0] pend_dat;

        // Reset state
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_valid", 32'(obs_valid), 32'd0);
        check("rst_data",  32'(obs_data),  32'd0);
        check("rst_occ",   32'(obs_occ),   32'd0);
        check("rst_ready", 32'(obs_ready), 32'd1);

        // Streaming 0x01..0x06 with no backpressure
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
            check("stream_ready", 32'(obs_ready), 32'd1);
            if (i == 3) check("lat_early", 32'(obs_valid), 32'd0);
            if (i == 4) begin
                check("lat_first_valid", 32'(obs_valid), 32'd1);
                check("lat_first_data",  32'(obs_data),  32'h01);
                check("stream_occ",      32'(obs_occ),   32'd3);
            end
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Fill under backpressure, hold a fourth beat, then release
        outq.delete();
        a_seq[0] = 8'hA0; a_seq[1] = 8'hA1; a_seq[2] = 8'hA2; a_seq[3] = 8'hA3;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, a_seq[i], 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b1, a_seq[3], 1'b0);
            check("stall_ready", 32'(obs_ready), 32'd0);
            check("stall_occ",   32'(obs_occ),   32'd3);
        end
        cyc(1'b0, 1'b0, 1'b1, a_seq[3], 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("release_count", 32'(outq.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < outq.size()) check("release_order", 32'(outq[i]), 32'(a_seq[i]));
        end

        // Full pipe with simultaneous push and pop
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'hB0 + i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 8'(8'hC0 + i), 1'b1);
            check("thru_occ",   32'(obs_occ),   32'd3);
            check("thru_ready", 32'(obs_ready), 32'd1);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Flush mid-stream, then a fresh beat
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 8'h13, 1'b1);
        check("flush_ready", 32'(obs_ready), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        check("flush_occ",   32'(obs_occ),   32'd0);
        check("flush_valid", 32'(obs_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("post_flush_early", 32'(obs_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("post_flush_valid", 32'(obs_valid), 32'd1);
        check("post_flush_data",  32'(obs_data),  32'h55);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Reset with a pipe full of 0xFF
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("full_ff_data", 32'(obs_data), 32'hFF);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        check("rst2_valid", 32'(obs_valid), 32'd0);
        check("rst2_data",  32'(obs_data),  32'd0);
        check("rst2_occ",   32'(obs_occ),   32'd0);
        check("rst2_ready", 32'(obs_ready), 32'd1);

`ifdef GATED_PIPE_CLK_GATE_EN
        // Stalled full pipe must not pulse any data clock
        begin
            int s0, s1, s2;
            for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'hD0 + i), 1'b0);
            cyc(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
            s0 = gp0; s1 = gp1; s2 = gp2;
            for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
            check("gclk0_idle", 32'(gp0 - s0), 32'd0);
            check("gclk1_idle", 32'(gp1 - s1), 32'd0);
            check("gclk2_idle", 32'(gp2 - s2), 32'd0);
            for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        end
`endif

        // Randomized traffic with a producer that holds its beat until accepted
        pend_vld = 1'b0;
        pend_dat = '0;
        for (int i = 0; i < 1500; i++) begin
            logic r_rst, r_flush, r_rin;
            if (!pend_vld && ($urandom_range(3, 0) != 0)) begin
                pend_vld = 1'b1;
                pend_dat = 8'($urandom());
            end
            r_rst   = ($urandom_range(149, 0) == 0);
            r_flush = ($urandom_range(39, 0) == 0);
            r_rin   = ($urandom_range(2, 0) != 0);
            cyc(r_rst, r_flush, pend_vld, pend_dat, r_rin);
            if (m_acc) pend_vld = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
